// File: rtl/miriscv_csr_unit_if.sv
// CSR access port between the decode/writeback stage and the CSR unit.
// The stage drives op/address/operand; the unit returns the old value and
// an illegal-access flag, both combinational.
interface miriscv_csr_unit_if;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (
    output csr_op, csr_addr, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_op, csr_addr, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/miriscv_csr_unit.sv
// miriscv M-mode CSR unit: trap CSRs, 64-bit mcycle/minstret, trap/mret
// stacking of mstatus.MIE and interrupt request generation.
// mstatus keeps only MIE/MPIE as state; MPP is hard-wired to machine mode.
module miriscv_csr_unit #(
  parameter int          NUM_IRQ     = 16,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MIE_RESET   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  miriscv_csr_unit_if.slave      csr,
  input  logic                   trap_i,
  input  logic [31:0]            trap_cause_i,
  input  logic [31:0]            trap_pc_i,
  input  logic                   mret_i,
  input  logic                   instr_retired_i,
  input  logic [NUM_IRQ-1:0]     irq_i,
  output logic                   irq_o,
  output logic [31:0]            irq_cause_o,
  output logic [31:0]            mie_o,
  output logic [31:0]            mtvec_o,
  output logic [31:0]            mepc_o
);

  localparam logic [31:0] IRQ_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << 16;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;

  logic               st_mie_q, st_mie_d;
  logic               st_mpie_q, st_mpie_d;
  logic [31:0]        mie_q, mie_d;
  logic [NUM_IRQ-1:0] mip_q;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mscratch_q, mscratch_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [63:0]        mcycle_q, mcycle_d;
  logic [63:0]        minstret_q, minstret_d;

  logic [31:0] mstatus_rd;
  logic [31:0] mip_full;
  logic [31:0] rdata;
  logic        impl;
  logic        read_only;
  logic        illegal;
  logic [31:0] wval;
  logic        csr_we;
  logic [31:0] pend;
  logic [4:0]  irq_idx;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
  assign mip_full   = 32'(mip_q) << 16;

  // Address decode: old value of the addressed CSR and access legality
  always_comb begin
    rdata     = '0;
    impl      = 1'b1;
    read_only = 1'b0;
    case (csr.csr_addr)
      A_MSTATUS:   rdata = mstatus_rd;
      A_MIE:       rdata = mie_q;
      A_MTVEC:     rdata = mtvec_q;
      A_MSCRATCH:  rdata = mscratch_q;
      A_MEPC:      rdata = mepc_q;
      A_MCAUSE:    rdata = mcause_q;
      A_MIP:       begin rdata = mip_full;              read_only = 1'b1; end
      A_MCYCLE:    rdata = mcycle_q[31:0];
      A_MINSTRET:  rdata = minstret_q[31:0];
      A_MCYCLEH:   rdata = mcycle_q[63:32];
      A_MINSTRETH: rdata = minstret_q[63:32];
      A_CYCLE:     begin rdata = mcycle_q[31:0];        read_only = 1'b1; end
      A_INSTRET:   begin rdata = minstret_q[31:0];      read_only = 1'b1; end
      A_CYCLEH:    begin rdata = mcycle_q[63:32];       read_only = 1'b1; end
      A_INSTRETH:  begin rdata = minstret_q[63:32];     read_only = 1'b1; end
      default:     impl = 1'b0;
    endcase
  end

  // Every non-zero op writes, so read-only targets are always illegal
  assign illegal         = (csr.csr_op != OP_NONE) && (!impl || read_only);
  assign csr.csr_rdata   = rdata;
  assign csr.csr_illegal = illegal;

  // Read-modify-write value for the addressed CSR
  always_comb begin
    wval = rdata;
    case (csr.csr_op)
      OP_RW:   wval = csr.csr_wdata;
      OP_RS:   wval = rdata | csr.csr_wdata;
      OP_RC:   wval = rdata & ~csr.csr_wdata;
      default: wval = rdata;
    endcase
  end

  // Trap and mret pre-empt the CSR write in the same cycle; it is dropped
  assign csr_we = (csr.csr_op != OP_NONE) && !illegal && !trap_i && !mret_i;

  // Next-state for trap CSRs and counters
  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + 64'(instr_retired_i);

    if (trap_i) begin
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
      mepc_d    = trap_pc_i & ~32'h1;
      mcause_d  = trap_cause_i;
    end else if (mret_i) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr.csr_addr)
        A_MSTATUS: begin
          st_mie_d  = wval[3];
          st_mpie_d = wval[7];
        end
        A_MIE:       mie_d      = wval & IRQ_MASK;
        A_MTVEC:     mtvec_d    = wval & ~32'h3;
        A_MSCRATCH:  mscratch_d = wval;
        A_MEPC:      mepc_d     = wval & ~32'h1;
        A_MCAUSE:    mcause_d   = wval;
        // A half-write freezes the whole counter for this cycle: no carry
        A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wval};
        A_MCYCLEH:   mcycle_d   = {wval, mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[63:32], wval};
        A_MINSTRETH: minstret_d = {wval, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= MIE_RESET & IRQ_MASK;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_RESET & ~32'h3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mip_q      <= irq_i;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign pend  = mip_full & mie_q;
  assign irq_o = st_mie_q & (|pend);

  // Lowest-numbered pending enabled line selects the cause
  always_comb begin
    irq_idx = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (pend[16 + k]) irq_idx = 5'(k);
    end
  end

  assign irq_cause_o = irq_o ? {1'b1, 26'b0, 5'd16 + irq_idx} : 32'h0;
  assign mie_o       = mie_q;
  assign mtvec_o     = mtvec_q;
  assign mepc_o      = mepc_q;

endmodule

// File: tb/tb_miriscv_csr_unit.sv
// Directed bench for miriscv_csr_unit (NUM_IRQ=4, non-zero reset parameters
// so reset masking of mie/mtvec is observable).
module tb_miriscv_csr_unit;
  localparam int NIRQ = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic trap_i = 1'b0;
  logic [31:0] trap_cause_i = '0;
  logic [31:0] trap_pc_i = '0;
  logic mret_i = 1'b0;
  logic instr_retired_i = 1'b0;
  logic [NIRQ-1:0] irq_i = '0;
  logic irq_o;
  logic [31:0] irq_cause_o, mie_o, mtvec_o, mepc_o;

  int total = 0;
  int bad = 0;
  logic [31:0] got;

  always #10 clk = ~clk;

  miriscv_csr_unit_if csr_if();

  miriscv_csr_unit #(
    .NUM_IRQ(NIRQ),
    .MTVEC_RESET(32'h0000_0107),
    .MIE_RESET(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .csr(csr_if),
    .trap_i(trap_i),
    .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i),
    .mret_i(mret_i),
    .instr_retired_i(instr_retired_i),
    .irq_i(irq_i),
    .irq_o(irq_o),
    .irq_cause_o(irq_cause_o),
    .mie_o(mie_o),
    .mtvec_o(mtvec_o),
    .mepc_o(mepc_o)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    csr_if.csr_op   = 2'b00;
    csr_if.csr_addr = a;
    #1;
    d = csr_if.csr_rdata;
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] v);
    csr_if.csr_op    = op;
    csr_if.csr_addr  = a;
    csr_if.csr_wdata = v;
    tick();
    csr_if.csr_op    = 2'b00;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq_o); end
    total++; if (irq_cause_o !== 32'h0) begin bad++; $display("FAIL rst_cause got=%h exp=00000000", irq_cause_o); end
    total++; if (mie_o !== 32'h000F_0000) begin bad++; $display("FAIL rst_mie got=%h exp=000f0000", mie_o); end
    total++; if (mtvec_o !== 32'h0000_0104) begin bad++; $display("FAIL rst_mtvec got=%h exp=00000104", mtvec_o); end
    total++; if (mepc_o !== 32'h0) begin bad++; $display("FAIL rst_mepc got=%h exp=00000000", mepc_o); end
    rd(12'h300, got);
    total++; if (got !== 32'h0000_1800) begin bad++; $display("FAIL rst_mstatus got=%h exp=00001800", got); end
    rd(12'hB00, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL rst_mcycle got=%h exp=00000000", got); end
    reset = 1'b0;
  endtask

  task automatic test_counters();
    for (int i = 0; i < 10; i++) tick();
    rd(12'hB00, got);
    total++; if (got !== 32'd10) begin bad++; $display("FAIL mcycle_idle got=%h exp=0000000a", got); end
    rd(12'hB02, got);
    total++; if (got !== 32'd0) begin bad++; $display("FAIL minstret_idle got=%h exp=00000000", got); end
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    wr(2'b01, 12'hB80, 32'h0);
    rd(12'hB00, got);
    total++; if (got !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mcycle_hold got=%h exp=ffffffff", got); end
    tick();
    rd(12'hB00, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL mcycle_carry_lo got=%h exp=00000000", got); end
    rd(12'hB80, got);
    total++; if (got !== 32'h1) begin bad++; $display("FAIL mcycle_carry_hi got=%h exp=00000001", got); end
    rd(12'hC80, got);
    total++; if (got !== 32'h1) begin bad++; $display("FAIL cycleh_alias got=%h exp=00000001", got); end
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    wr(2'b01, 12'hB80, 32'hFFFF_FFFF);
    tick();
    rd(12'hB00, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL wrap_lo got=%h exp=00000000", got); end
    rd(12'hB80, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL wrap_hi got=%h exp=00000000", got); end
    instr_retired_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    instr_retired_i = 1'b0;
    rd(12'hB02, got);
    total++; if (got !== 32'd3) begin bad++; $display("FAIL minstret_count got=%h exp=00000003", got); end
    rd(12'hC02, got);
    total++; if (got !== 32'd3) begin bad++; $display("FAIL instret_alias got=%h exp=00000003", got); end
    instr_retired_i = 1'b1;
    wr(2'b01, 12'hB02, 32'h10);
    instr_retired_i = 1'b0;
    rd(12'hB02, got);
    total++; if (got !== 32'h10) begin bad++; $display("FAIL minstret_write got=%h exp=00000010", got); end
  endtask

  task automatic test_irq_trap();
    wr(2'b01, 12'h304, 32'h0001_0000);
    wr(2'b01, 12'h300, 32'h8);
    irq_i = 4'b0001;
    #1;
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_latency got=%b exp=0", irq_o); end
    tick();
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_raise got=%b exp=1", irq_o); end
    total++; if (irq_cause_o !== 32'h8000_0010) begin bad++; $display("FAIL irq_cause0 got=%h exp=80000010", irq_cause_o); end
    trap_i = 1'b1; trap_pc_i = 32'h0000_0103; trap_cause_i = 32'h8000_0010;
    tick();
    trap_i = 1'b0;
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL trap_irq got=%b exp=0", irq_o); end
    total++; if (mepc_o !== 32'h0000_0102) begin bad++; $display("FAIL trap_mepc_o got=%h exp=00000102", mepc_o); end
    rd(12'h342, got);
    total++; if (got !== 32'h8000_0010) begin bad++; $display("FAIL trap_mcause got=%h exp=80000010", got); end
    rd(12'h300, got);
    total++; if (got !== 32'h0000_1880) begin bad++; $display("FAIL trap_mstatus got=%h exp=00001880", got); end
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    rd(12'h300, got);
    total++; if (got !== 32'h0000_1888) begin bad++; $display("FAIL mret_mstatus got=%h exp=00001888", got); end
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL mret_irq got=%b exp=1", irq_o); end
    wr(2'b10, 12'h304, 32'h000E_0000);
    total++; if (mie_o !== 32'h000F_0000) begin bad++; $display("FAIL mie_rs got=%h exp=000f0000", mie_o); end
    irq_i = 4'b0110;
    tick();
    total++; if (irq_cause_o !== 32'h8000_0011) begin bad++; $display("FAIL irq_lowest got=%h exp=80000011", irq_cause_o); end
    rd(12'h344, got);
    total++; if (got !== 32'h0006_0000) begin bad++; $display("FAIL mip_read got=%h exp=00060000", got); end
    irq_i = 4'b1000;
    tick();
    total++; if (irq_cause_o !== 32'h8000_0013) begin bad++; $display("FAIL irq_top got=%h exp=80000013", irq_cause_o); end
  endtask

  task automatic test_priority();
    wr(2'b01, 12'h340, 32'h1234_5678);
    trap_i = 1'b1; trap_pc_i = 32'h0000_0200; trap_cause_i = 32'h0000_000B;
    csr_if.csr_op = 2'b01; csr_if.csr_addr = 12'h340; csr_if.csr_wdata = 32'hDEAD_BEEF;
    tick();
    trap_i = 1'b0;
    csr_if.csr_op = 2'b00;
    rd(12'h340, got);
    total++; if (got !== 32'h1234_5678) begin bad++; $display("FAIL trap_drops_write got=%h exp=12345678", got); end
    rd(12'h341, got);
    total++; if (got !== 32'h0000_0200) begin bad++; $display("FAIL trap2_mepc got=%h exp=00000200", got); end
    rd(12'h342, got);
    total++; if (got !== 32'h0000_000B) begin bad++; $display("FAIL trap2_mcause got=%h exp=0000000b", got); end
    mret_i = 1'b1;
    wr(2'b11, 12'h300, 32'h8);
    mret_i = 1'b0;
    rd(12'h300, got);
    total++; if (got !== 32'h0000_1888) begin bad++; $display("FAIL mret_drops_write got=%h exp=00001888", got); end
  endtask

  task automatic test_illegal();
    csr_if.csr_op = 2'b10; csr_if.csr_addr = 12'hC00; csr_if.csr_wdata = 32'h1;
    #1;
    total++; if (csr_if.csr_illegal !== 1'b1) begin bad++; $display("FAIL ill_cycle_rs got=%b exp=1", csr_if.csr_illegal); end
    wr(2'b01, 12'hC02, 32'h55);
    rd(12'hB02, got);
    total++; if (got !== 32'h10) begin bad++; $display("FAIL ill_no_write got=%h exp=00000010", got); end
    csr_if.csr_op = 2'b01; csr_if.csr_addr = 12'h344; csr_if.csr_wdata = 32'h0;
    #1;
    total++; if (csr_if.csr_illegal !== 1'b1) begin bad++; $display("FAIL ill_mip_rw got=%b exp=1", csr_if.csr_illegal); end
    csr_if.csr_op = 2'b10; csr_if.csr_addr = 12'h7C0;
    #1;
    total++; if (csr_if.csr_illegal !== 1'b1) begin bad++; $display("FAIL ill_unimpl got=%b exp=1", csr_if.csr_illegal); end
    total++; if (csr_if.csr_rdata !== 32'h0) begin bad++; $display("FAIL unimpl_rdata got=%h exp=00000000", csr_if.csr_rdata); end
    csr_if.csr_op = 2'b01; csr_if.csr_addr = 12'h341;
    #1;
    total++; if (csr_if.csr_illegal !== 1'b0) begin bad++; $display("FAIL legal_mepc got=%b exp=0", csr_if.csr_illegal); end
    csr_if.csr_op = 2'b00;
    tick();
    wr(2'b01, 12'h305, 32'h0000_1003);
    rd(12'h305, got);
    total++; if (got !== 32'h0000_1000) begin bad++; $display("FAIL mtvec_legal got=%h exp=00001000", got); end
    total++; if (mtvec_o !== 32'h0000_1000) begin bad++; $display("FAIL mtvec_o got=%h exp=00001000", mtvec_o); end
    wr(2'b01, 12'h341, 32'h0000_0301);
    total++; if (mepc_o !== 32'h0000_0300) begin bad++; $display("FAIL mepc_legal got=%h exp=00000300", mepc_o); end
    wr(2'b01, 12'h300, 32'hFFFF_FFFF);
    rd(12'h300, got);
    total++; if (got !== 32'h0000_1888) begin bad++; $display("FAIL mstatus_mask got=%h exp=00001888", got); end
    wr(2'b01, 12'h304, 32'hFFFF_FFFF);
    total++; if (mie_o !== 32'h000F_0000) begin bad++; $display("FAIL mie_mask got=%h exp=000f0000", mie_o); end
  endtask

  task automatic test_async_reset();
    tick();
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got=%b exp=1", irq_o); end
    #3;
    reset = 1'b1;
    #1;
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL arst_irq got=%b exp=0", irq_o); end
    total++; if (irq_cause_o !== 32'h0) begin bad++; $display("FAIL arst_cause got=%h exp=00000000", irq_cause_o); end
    total++; if (mepc_o !== 32'h0) begin bad++; $display("FAIL arst_mepc got=%h exp=00000000", mepc_o); end
    total++; if (mtvec_o !== 32'h0000_0104) begin bad++; $display("FAIL arst_mtvec got=%h exp=00000104", mtvec_o); end
    total++; if (mie_o !== 32'h000F_0000) begin bad++; $display("FAIL arst_mie got=%h exp=000f0000", mie_o); end
    rd(12'hB00, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL arst_mcycle got=%h exp=00000000", got); end
    rd(12'hB02, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL arst_minstret got=%h exp=00000000", got); end
    rd(12'h300, got);
    total++; if (got !== 32'h0000_1800) begin bad++; $display("FAIL arst_mstatus got=%h exp=00001800", got); end
    rd(12'h340, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL arst_mscratch got=%h exp=00000000", got); end
    rd(12'h344, got);
    total++; if (got !== 32'h0) begin bad++; $display("FAIL arst_mip got=%h exp=00000000", got); end
    tick();
    tick();
    reset = 1'b0;
    tick();
    rd(12'hB00, got);
    total++; if (got !== 32'h1) begin bad++; $display("FAIL post_reset_mcycle got=%h exp=00000001", got); end
  endtask

  initial begin
    csr_if.csr_op    = 2'b00;
    csr_if.csr_addr  = 12'h000;
    csr_if.csr_wdata = 32'h0;
    test_reset();
    test_counters();
    test_irq_trap();
    test_priority();
    test_illegal();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
